// File: rtl/bomb_pkg.sv
// Shared types and default timing constants for the bomb sprite sequencer.
package bomb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EXPLODE = 2'd2
  } bomb_state_t;

  localparam int BOMB_FUSE_FRAMES    = 180;
  localparam int BOMB_BLINK_FRAMES   = 15;
  localparam int BOMB_EXPLODE_FRAMES = 30;

endpackage

// File: rtl/bomb_tick_counter.sv
// Frame-tick counter with a registered flag that is high while the count sits at TERM-1.
// Clear wins over en; a tick taken at the terminal count wraps back to zero.
module bomb_tick_counter #(
  parameter int TERM = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  localparam int W = (TERM > 1) ? $clog2(TERM) : 1;
  localparam logic [W-1:0] LAST = W'(TERM - 1);
  localparam logic TERM_AT_ZERO = (LAST == '0);

  logic [W-1:0] cnt_q, cnt_d;
  logic         terminal_q, terminal_d;

  always_comb begin
    cnt_d      = cnt_q;
    terminal_d = terminal_q;
    if (clear) begin
      cnt_d      = '0;
      terminal_d = TERM_AT_ZERO;
    end else if (en) begin
      if (terminal_q) begin
        cnt_d      = '0;
        terminal_d = TERM_AT_ZERO;
      end else begin
        cnt_d      = cnt_q + W'(1);
        terminal_d = ((cnt_q + W'(1)) == LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      terminal_q <= TERM_AT_ZERO;
    end else begin
      cnt_q      <= cnt_d;
      terminal_q <= terminal_d;
    end
  end

  assign terminal = terminal_q;

endmodule

// File: rtl/bomb_ctrl.sv
// Bomb sprite sequencer: place -> fuse countdown with blink -> explosion -> idle.
// All outputs registered, 1 cycle after the accepting/terminal edge; no backpressure.
module bomb_ctrl
  import bomb_pkg::*;
#(
  parameter int FUSE_FRAMES    = BOMB_FUSE_FRAMES,
  parameter int BLINK_FRAMES   = BOMB_BLINK_FRAMES,
  parameter int EXPLODE_FRAMES = BOMB_EXPLODE_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       place_req,
  input  logic [9:0] place_x,
  input  logic [9:0] place_y,
  input  logic       detonate,
  output logic       place_ack,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic       pos,
  output logic       active,
  output logic       exploding,
  output logic       explode_pulse,
  output logic       done
);

  bomb_state_t state_q, state_d;
  logic [9:0]  posx_q, posx_d, posy_q, posy_d;
  logic        pos_q, pos_d;
  logic        ack_q, ack_d;
  logic        active_q, active_d;
  logic        exploding_q, exploding_d;
  logic        pulse_q, pulse_d;
  logic        done_q, done_d;

  logic clr_arm, clr_exp, fuse_en, blink_en, exp_en, go_exp;
  logic fuse_term, blink_term, exp_term;

  bomb_tick_counter #(.TERM(FUSE_FRAMES)) u_fuse (
    .clk(clk), .rst(rst), .clear(clr_arm), .en(fuse_en), .terminal(fuse_term)
  );

  bomb_tick_counter #(.TERM(BLINK_FRAMES)) u_blink (
    .clk(clk), .rst(rst), .clear(clr_arm), .en(blink_en), .terminal(blink_term)
  );

  bomb_tick_counter #(.TERM(EXPLODE_FRAMES)) u_explode (
    .clk(clk), .rst(rst), .clear(clr_exp), .en(exp_en), .terminal(exp_term)
  );

  always_comb begin
    state_d  = state_q;
    posx_d   = posx_q;
    posy_d   = posy_q;
    pos_d    = pos_q;
    ack_d    = 1'b0;
    pulse_d  = 1'b0;
    done_d   = 1'b0;
    clr_arm  = 1'b0;
    clr_exp  = 1'b0;
    fuse_en  = 1'b0;
    blink_en = 1'b0;
    exp_en   = 1'b0;
    go_exp   = 1'b0;

    case (state_q)
      IDLE: begin
        if (place_req) begin
          state_d = ARMED;
          posx_d  = place_x;
          posy_d  = place_y;
          pos_d   = 1'b0;
          ack_d   = 1'b1;
          clr_arm = 1'b1;
        end
      end
      ARMED: begin
        // A detonate swallows a coincident tick entirely.
        if (detonate) begin
          go_exp = 1'b1;
        end else if (frame_tick) begin
          fuse_en  = 1'b1;
          blink_en = 1'b1;
          if (blink_term) pos_d = ~pos_q;
          if (fuse_term)  go_exp = 1'b1;
        end
      end
      EXPLODE: begin
        if (frame_tick) begin
          if (exp_term) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            exp_en = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_exp) begin
      state_d = EXPLODE;
      pos_d   = 1'b0;
      pulse_d = 1'b1;
      clr_exp = 1'b1;
    end
  end

  assign active_d    = (state_d != IDLE);
  assign exploding_d = (state_d == EXPLODE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      posx_q      <= '0;
      posy_q      <= '0;
      pos_q       <= 1'b0;
      ack_q       <= 1'b0;
      active_q    <= 1'b0;
      exploding_q <= 1'b0;
      pulse_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      posx_q      <= posx_d;
      posy_q      <= posy_d;
      pos_q       <= pos_d;
      ack_q       <= ack_d;
      active_q    <= active_d;
      exploding_q <= exploding_d;
      pulse_q     <= pulse_d;
      done_q      <= done_d;
    end
  end

  assign place_ack     = ack_q;
  assign posx          = posx_q;
  assign posy          = posy_q;
  assign pos           = pos_q;
  assign active        = active_q;
  assign exploding     = exploding_q;
  assign explode_pulse = pulse_q;
  assign done          = done_q;

endmodule

// File: tb/tb_bomb_ctrl.sv
// Bench for bomb_ctrl with FUSE=4, BLINK=2, EXPLODE=3: vector table, reset sequences, random vs model.
module tb_bomb_ctrl;

  localparam int FUSE  = 4;
  localparam int BLINK = 2;
  localparam int EXPL  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       place_req = 1'b0;
  logic       detonate = 1'b0;
  logic [9:0] place_x = '0;
  logic [9:0] place_y = '0;
  logic       place_ack, pos, active, exploding, explode_pulse, done;
  logic [9:0] posx, posy;

  bomb_ctrl #(
    .FUSE_FRAMES(FUSE), .BLINK_FRAMES(BLINK), .EXPLODE_FRAMES(EXPL)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .place_req(place_req),
    .place_x(place_x), .place_y(place_y), .detonate(detonate),
    .place_ack(place_ack), .posx(posx), .posy(posy), .pos(pos),
    .active(active), .exploding(exploding), .explode_pulse(explode_pulse), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ack, act, ex, pu, dn, pos;
    logic [9:0] px, py;
  } out_t;

  typedef struct {
    logic       req;
    logic [9:0] x, y;
    logic       tick, det;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic req, input int x, input int y, input logic tick, input logic det,
                     input logic ack, input logic act, input logic ex, input logic pu,
                     input logic dn, input logic p, input int px, input int py);
    vec_t v;
    v.req  = req;
    v.x    = 10'(x);
    v.y    = 10'(y);
    v.tick = tick;
    v.det  = det;
    v.exp  = {ack, act, ex, pu, dn, p, 10'(px), 10'(py)};
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input out_t want);
    out_t got;
    got = {place_ack, active, exploding, explode_pulse, done, pos, posx, posy};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got ack=%b act=%b exp=%b pulse=%b done=%b pos=%b x=%0d y=%0d, want ack=%b act=%b exp=%b pulse=%b done=%b pos=%b x=%0d y=%0d",
               nm, got.ack, got.act, got.ex, got.pu, got.dn, got.pos, got.px, got.py,
               want.ack, want.act, want.ex, want.pu, want.dn, want.pos, want.px, want.py);
    end
  endtask

  // One cycle: inputs change on the falling edge, outputs are sampled 1 ns after the rising edge.
  task automatic apply(input logic r, input logic req, input logic [9:0] x, input logic [9:0] y,
                       input logic tick, input logic det);
    @(negedge clk);
    rst        = r;
    place_req  = req;
    place_x    = x;
    place_y    = y;
    frame_tick = tick;
    detonate   = det;
    @(posedge clk);
    #1;
  endtask

  // Reference model: phase plus tick count within the phase; pos derived by division.
  int         m_phase;  // 0 idle, 1 armed, 2 exploding
  int         m_ticks;
  logic [9:0] m_x, m_y;
  logic       m_ack, m_xp, m_done;

  task automatic model_step(input logic r, input logic req, input logic [9:0] x, input logic [9:0] y,
                            input logic tick, input logic det);
    m_ack  = 1'b0;
    m_xp   = 1'b0;
    m_done = 1'b0;
    if (r) begin
      m_phase = 0; m_ticks = 0; m_x = '0; m_y = '0;
    end else if (m_phase == 0) begin
      if (req) begin
        m_phase = 1; m_ticks = 0; m_x = x; m_y = y; m_ack = 1'b1;
      end
    end else if (m_phase == 1) begin
      if (det) begin
        m_phase = 2; m_ticks = 0; m_xp = 1'b1;
      end else if (tick) begin
        m_ticks++;
        if (m_ticks == FUSE) begin
          m_phase = 2; m_ticks = 0; m_xp = 1'b1;
        end
      end
    end else if (tick) begin
      m_ticks++;
      if (m_ticks == EXPL) begin
        m_phase = 0; m_ticks = 0; m_done = 1'b1;
      end
    end
  endtask

  function automatic out_t model_out();
    logic p;
    p = (m_phase == 1) && (((m_ticks / BLINK) % 2) == 1);
    return {m_ack, m_phase != 0, m_phase == 2, m_xp, m_done, p, m_x, m_y};
  endfunction

  initial begin
    out_t zero;
    zero = '0;

    //   req  x    y  tick det | ack act ex pu dn pos  px   py
    add(1, 100, 200, 0, 0,   1, 1, 0, 0, 0, 0, 100, 200);  // accept
    add(0,   0,   0, 0, 0,   0, 1, 0, 0, 0, 0, 100, 200);
    add(0,   0,   0, 1, 0,   0, 1, 0, 0, 0, 0, 100, 200);  // tick 1
    add(0,   0,   0, 1, 0,   0, 1, 0, 0, 0, 1, 100, 200);  // tick 2: toggle
    add(1,   5,   5, 0, 0,   0, 1, 0, 0, 0, 1, 100, 200);  // req while armed ignored
    add(0,   0,   0, 1, 0,   0, 1, 0, 0, 0, 1, 100, 200);  // tick 3
    add(0,   0,   0, 1, 0,   0, 1, 1, 1, 0, 0, 100, 200);  // tick 4: explode
    add(0,   0,   0, 0, 0,   0, 1, 1, 0, 0, 0, 100, 200);
    add(1,   5,   5, 0, 0,   0, 1, 1, 0, 0, 0, 100, 200);  // req while exploding ignored
    add(0,   0,   0, 1, 0,   0, 1, 1, 0, 0, 0, 100, 200);
    add(0,   0,   0, 1, 0,   0, 1, 1, 0, 0, 0, 100, 200);
    add(0,   0,   0, 1, 0,   0, 0, 0, 0, 1, 0, 100, 200);  // done
    add(0,   0,   0, 0, 0,   0, 0, 0, 0, 0, 0, 100, 200);
    add(0,   0,   0, 0, 1,   0, 0, 0, 0, 0, 0, 100, 200);  // detonate in idle ignored
    add(1, 300, 400, 0, 0,   1, 1, 0, 0, 0, 0, 300, 400);
    add(0,   0,   0, 1, 0,   0, 1, 0, 0, 0, 0, 300, 400);
    add(0,   0,   0, 1, 1,   0, 1, 1, 1, 0, 0, 300, 400);  // detonate + tick
    add(0,   0,   0, 1, 0,   0, 1, 1, 0, 0, 0, 300, 400);
    add(0,   0,   0, 1, 0,   0, 1, 1, 0, 0, 0, 300, 400);
    add(0,   0,   0, 1, 0,   0, 0, 0, 0, 1, 0, 300, 400);  // 3 ticks of explosion
    add(1,   7,   8, 1, 0,   1, 1, 0, 0, 0, 0,   7,   8);  // accept + tick
    add(0,   0,   0, 1, 0,   0, 1, 0, 0, 0, 0,   7,   8);
    add(0,   0,   0, 1, 0,   0, 1, 0, 0, 0, 1,   7,   8);
    add(0,   0,   0, 1, 0,   0, 1, 0, 0, 0, 1,   7,   8);
    add(0,   0,   0, 1, 0,   0, 1, 1, 1, 0, 0,   7,   8);  // 4th tick after accept
    add(0,   0,   0, 0, 1,   0, 1, 1, 0, 0, 0,   7,   8);  // detonate while exploding ignored
    add(0,   0,   0, 1, 0,   0, 1, 1, 0, 0, 0,   7,   8);
    add(1,   9,  10, 1, 0,   0, 1, 1, 0, 0, 0,   7,   8);
    add(1,   9,  10, 1, 0,   0, 0, 0, 0, 1, 0,   7,   8);  // done, req held
    add(1,   9,  10, 0, 0,   1, 1, 0, 0, 0, 0,   9,  10);  // ack one cycle after done
    add(0,   0,   0, 0, 1,   0, 1, 1, 1, 0, 0,   9,  10);  // detonate from armed

    repeat (2) @(posedge clk);
    #1;
    check("reset_held", zero);
    apply(0, 0, 0, 0, 0, 0);
    check("reset_released", zero);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(0, vecs[i].req, vecs[i].x, vecs[i].y, vecs[i].tick, vecs[i].det);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset in the middle of the explosion left running by the table.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_explode_async", zero);
    apply(1, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 1, 0);
    check("rst_explode_no_done", zero);
    apply(0, 1, 11, 12, 0, 0);
    check("rst_explode_reaccept", {1'b1, 1'b1, 4'b0, 10'd11, 10'd12});
    apply(0, 0, 0, 0, 1, 0);
    check("armed_after_reaccept", {1'b0, 1'b1, 4'b0, 10'd11, 10'd12});

    // Reset in the middle of the fuse.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_armed_async", zero);
    apply(0, 0, 0, 0, 1, 0);
    check("rst_armed_no_done", zero);
    apply(0, 1, 13, 14, 0, 0);
    check("rst_armed_reaccept", {1'b1, 1'b1, 4'b0, 10'd13, 10'd14});

    for (int i = 0; i < 3000; i++) begin
      logic       r, req, tick, det;
      logic [9:0] x, y;
      r    = (i == 0) || ($urandom_range(99) == 0);
      req  = ($urandom_range(3) == 0);
      tick = ($urandom_range(2) == 0);
      det  = ($urandom_range(15) == 0);
      x    = 10'($urandom);
      y    = 10'($urandom);
      model_step(r, req, x, y, tick, det);
      apply(r, req, x, y, tick, det);
      check($sformatf("rand%0d", i), model_out());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
